// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size codes and FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way requester selector: fixed priority (port 0) or round-robin against the last winner.
module dmem_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // Only a tie needs a policy; a lone requester always wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU LSU (port 0) and the loader/DMA (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  grant
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE * 4);

  state_t                  state, state_next;
  logic                    gnt_q, last_q, err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    winner;
  logic                    sel_we, f3_ok, legal;
  logic [2:0]              sel_f3;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req    ({p1_req, p0_req}),
    .last   (last_q),
    .winner (winner)
  );

  always_comb begin
    sel_we    = gnt_q ? p1_we     : p0_we;
    sel_f3    = gnt_q ? p1_funct3 : p0_funct3;
    sel_addr  = gnt_q ? p1_addr   : p0_addr;
    sel_wdata = gnt_q ? p1_wdata  : p0_wdata;
    if (sel_we) f3_ok = (sel_f3 == F3_B) || (sel_f3 == F3_W);
    else        f3_ok = (sel_f3 == F3_B) || (sel_f3 == F3_W) || (sel_f3 == F3_BU);
    legal = f3_ok && (sel_addr < ADDR_LIMIT) &&
            !((sel_f3 == F3_W) && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    mem_wr_en   = 1'b0;
    mem_funct3  = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    p0_ack      = 1'b0;
    p0_err      = 1'b0;
    p0_rdata    = '0;
    p1_ack      = 1'b0;
    p1_err      = 1'b0;
    p1_rdata    = '0;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) state_next = ACCESS;
      end
      ACCESS: begin
        state_next  = ACK;
        grant       = gnt_q;
        mem_funct3  = sel_f3;
        mem_addr    = sel_addr;
        mem_wr_data = sel_wdata;
        // Reset landing in this cycle must suppress the write at the closing edge.
        mem_wr_en   = sel_we && legal && !reset;
      end
      ACK: begin
        state_next = IDLE;
        grant      = gnt_q;
        if (gnt_q) begin
          p1_ack   = 1'b1;
          p1_err   = err_q;
          p1_rdata = rdata_q;
        end else begin
          p0_ack   = 1'b1;
          p0_err   = err_q;
          p0_rdata = rdata_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (p0_req || p1_req)) begin
        gnt_q  <= winner;
        last_q <= winner;
      end
      if (state == ACCESS) begin
        err_q   <= ~legal;
        rdata_q <= (!sel_we && legal) ? mem_rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-array reference.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [2:0]  p0_funct3;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [2:0]  p1_funct3;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_wr_en, grant;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  // Second instance, fixed priority, stateless memory stand-in.
  logic        f_p0_req, f_p1_req, f_p0_ack, f_p1_ack, f_p0_err, f_p1_err;
  logic [31:0] f_p0_rdata, f_p1_rdata;
  logic        f_mem_wr_en, f_grant;
  logic [2:0]  f_mem_funct3;
  logic [31:0] f_mem_addr, f_mem_wr_data, f_mem_rd_data;
  assign f_mem_rd_data = f_mem_addr ^ 32'h5A5A_0000;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .grant(grant)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64), .FIXED_PRIO(1)) dut_fix (
    .clk(clk), .reset(reset),
    .p0_req(f_p0_req), .p0_we(1'b0), .p0_funct3(F3_W), .p0_addr(32'h8), .p0_wdata(32'h0),
    .p0_ack(f_p0_ack), .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_we(1'b0), .p1_funct3(F3_W), .p1_addr(32'hC), .p1_wdata(32'h0),
    .p1_ack(f_p1_ack), .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
    .mem_wr_en(f_mem_wr_en), .mem_funct3(f_mem_funct3), .mem_addr(f_mem_addr),
    .mem_wr_data(f_mem_wr_data), .mem_rd_data(f_mem_rd_data), .grant(f_grant)
  );

  // data_mem stand-in: word array, combinational read, byte/word write.
  logic [31:0] words [64];
  logic [31:0] mw;
  logic [7:0]  mb;
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  always_comb begin
    mw = words[mem_addr[7:2]];
    case (mem_addr[1:0])
      2'd0:    mb = mw[7:0];
      2'd1:    mb = mw[15:8];
      2'd2:    mb = mw[23:16];
      default: mb = mw[31:24];
    endcase
    case (mem_funct3)
      3'b010:  mem_rd_data = mw;
      3'b000:  mem_rd_data = {{24{mb[7]}}, mb};
      3'b100:  mem_rd_data = {24'h0, mb};
      default: mem_rd_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (mem_funct3 == 3'b010) words[mem_addr[7:2]] <= mem_wr_data;
      else case (mem_addr[1:0])
        2'd0:    words[mem_addr[7:2]][7:0]   <= mem_wr_data[7:0];
        2'd1:    words[mem_addr[7:2]][15:8]  <= mem_wr_data[7:0];
        2'd2:    words[mem_addr[7:2]][23:16] <= mem_wr_data[7:0];
        default: words[mem_addr[7:2]][31:24] <= mem_wr_data[7:0];
      endcase
    end else if (poke_en) begin
      words[poke_idx] <= poke_data;
    end
  end

  int wr_count = 0;
  always @(negedge clk) if (mem_wr_en) wr_count++;

  // Reference model: flat byte-addressed memory and the legality rules.
  logic [7:0] ref_mem [256];
  int tests = 0;
  int fails = 0;

  function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (we) ok = (f3 == 3'b000) || (f3 == 3'b010);
    else    ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100);
    return ok && (a < 32'd256) && !(f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b;
    if (!ref_legal(1'b0, f3, a)) return 32'h0;
    b = ref_mem[a[7:0]];
    case (f3)
      3'b010:  return {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], b};
      3'b000:  return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  task automatic ref_write(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    if (f3 == 3'b010) begin
      for (int k = 0; k < 4; k++) ref_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
    end else begin
      ref_mem[a[7:0]] = d[7:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit en, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (!port) begin
      p0_req = en; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = en; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one transaction from IDLE and returns in IDLE; lat = edges until ack, -1 on timeout.
  task automatic run_txn(input bit port, input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic err,
                         output logic [31:0] rd, output bit stray);
    lat = -1; err = 1'bx; rd = 'x; stray = 1'b0;
    drive(port, 1'b1, we, f3, a, d);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (port ? p0_ack : p1_ack) stray = 1'b1;
      if (port ? p1_ack : p0_ack) begin
        lat = i;
        err = port ? p1_err : p0_err;
        rd  = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({grant, p0_ack, p0_err, p1_ack, p1_err, mem_wr_en} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b want=000000", {grant, p0_ack, p0_err, p1_ack, p1_err, mem_wr_en});
    end
    tests++;
    if ({p0_rdata, p1_rdata, mem_addr, mem_wr_data} !== 128'h0) begin
      fails++; $display("FAIL reset_data got p0_rdata=%h p1_rdata=%h mem_addr=%h want 0", p0_rdata, p1_rdata, mem_addr);
    end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd; bit stray; int w0;
    w0 = wr_count;
    run_txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, err, rd, stray);
    ref_write(3'b010, 32'h10, 32'hDEADBEEF);
    tests++;
    if (lat !== 2 || err !== 1'b0) begin
      fails++; $display("FAIL wr_ack got lat=%0d err=%b want lat=2 err=0", lat, err);
    end
    tests++;
    if (wr_count - w0 !== 1) begin
      fails++; $display("FAIL wr_pulse got=%0d want=1", wr_count - w0);
    end
    run_txn(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, lat, err, rd, stray);
    tests++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF || stray) begin
      fails++; $display("FAIL rd_word got lat=%0d err=%b rdata=%h stray=%b want 2 0 deadbeef 0", lat, err, rd, stray);
    end
  endtask

  task automatic test_byte_read();
    int lat; logic err; logic [31:0] rd; bit stray;
    poke_en = 1'b1; poke_idx = 6'd32; poke_data = 32'h12345680;
    tick();
    poke_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[128 + k] = poke_data[8*k +: 8];
    run_txn(1'b0, 1'b0, 3'b000, 32'h80, 32'h0, lat, err, rd, stray);
    tests++;
    if (rd !== ref_read(3'b000, 32'h80) || rd !== 32'hFFFFFF80 || err !== 1'b0) begin
      fails++; $display("FAIL lb got rdata=%h err=%b want ffffff80 0", rd, err);
    end
    run_txn(1'b0, 1'b0, 3'b100, 32'h80, 32'h0, lat, err, rd, stray);
    tests++;
    if (rd !== ref_read(3'b100, 32'h80) || rd !== 32'h00000080 || err !== 1'b0) begin
      fails++; $display("FAIL lbu got rdata=%h err=%b want 00000080 0", rd, err);
    end
  endtask

  task automatic test_illegal();
    int lat; logic err; logic [31:0] rd; bit stray; int w0;
    w0 = wr_count;
    run_txn(1'b1, 1'b1, 3'b100, 32'h4, 32'h11223344, lat, err, rd, stray);
    tests++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0 || stray) begin
      fails++; $display("FAIL ill_wr got lat=%0d err=%b rdata=%h stray=%b want 2 1 0 0", lat, err, rd, stray);
    end
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, lat, err, rd, stray);
    tests++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL ill_rd got lat=%0d err=%b rdata=%h want 2 1 0", lat, err, rd);
    end
    tests++;
    if (wr_count !== w0) begin
      fails++; $display("FAIL ill_nowrite got=%0d want=%0d", wr_count, w0);
    end
  endtask

  task automatic test_rr_contention();
    int n; int cyc; int last_cyc; bit exp_last; bit exp; bit port;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h25, 32'h0);
    n = 0; cyc = 0; last_cyc = 0; exp_last = 1'b1;
    while (n < 4 && cyc < 30) begin
      tick(); cyc++;
      if (p0_ack || p1_ack) begin
        port = p1_ack;
        exp = ~exp_last; exp_last = exp;
        tests++;
        if (port !== exp || (p0_ack && p1_ack) || grant !== exp) begin
          fails++; $display("FAIL rr_order #%0d got p0_ack=%b p1_ack=%b grant=%b want port %0d", n, p0_ack, p1_ack, grant, exp);
        end
        tests++;
        if (cyc - last_cyc !== ((n == 0) ? 2 : 3)) begin
          fails++; $display("FAIL rr_spacing #%0d got=%0d want=%0d", n, cyc - last_cyc, (n == 0) ? 2 : 3);
        end
        tests++;
        if ((port ? p1_rdata : p0_rdata) !== (port ? ref_read(3'b000, 32'h25) : ref_read(3'b010, 32'h20))) begin
          fails++; $display("FAIL rr_rdata #%0d got=%h", n, port ? p1_rdata : p0_rdata);
        end
        last_cyc = cyc; n++;
      end
    end
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL rr_timeout got=%0d acks want=4", n);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_fixed_prio();
    int n; int cyc; bit exp;
    apply_reset();
    f_p0_req = 1'b1; f_p1_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      tick(); cyc++;
      if (f_p0_ack || f_p1_ack) begin
        exp = (n >= 3);
        tests++;
        if (f_p1_ack !== exp || f_p0_ack !== ~exp || f_grant !== exp) begin
          fails++; $display("FAIL fix_order #%0d got p0_ack=%b p1_ack=%b want port %0d", n, f_p0_ack, f_p1_ack, exp);
        end
        if (n == 0) begin
          tests++;
          if (f_p0_rdata !== (32'h8 ^ 32'h5A5A_0000) || f_p0_err !== 1'b0) begin
            fails++; $display("FAIL fix_rdata got=%h err=%b want=5a5a0008 0", f_p0_rdata, f_p0_err);
          end
        end
        n++;
        if (n == 3) f_p0_req = 1'b0;
      end
    end
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL fix_timeout got=%0d acks want=4", n);
    end
    f_p0_req = 1'b0; f_p1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int lat; logic err; logic [31:0] rd; bit stray; int w0; int acks;
    w0 = wr_count;
    drive(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    tick();
    tests++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'h40) begin
      fails++; $display("FAIL mid_access_pre got wr_en=%b addr=%h want 1 00000040", mem_wr_en, mem_addr);
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    tests++;
    if (mem_wr_en !== 1'b0) begin
      fails++; $display("FAIL mid_reset_wren got=%b want=0", mem_wr_en);
    end
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (p0_ack || p1_ack || grant) acks++;
    end
    tests++;
    if (acks !== 0 || wr_count !== w0) begin
      fails++; $display("FAIL mid_reset_quiet got acks=%0d writes=%0d want 0 0", acks, wr_count - w0);
    end
    run_txn(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, lat, err, rd, stray);
    tests++;
    if (lat !== 2 || rd !== ref_read(3'b010, 32'h40) || err !== 1'b0) begin
      fails++; $display("FAIL mid_reset_mem got lat=%0d rdata=%h want 2 %h", lat, rd, ref_read(3'b010, 32'h40));
    end
  endtask

  // Randomized traffic: next winner is predicted from the pending set and the last winner.
  bit          t_pend [2];
  bit          t_we   [2];
  logic [2:0]  t_f3   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];

  task automatic gen(input bit port);
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0, 4:    t_f3[port] = 3'b000;
      1, 5, 6: t_f3[port] = 3'b010;
      2:       t_f3[port] = 3'b100;
      default: t_f3[port] = 3'($urandom_range(0, 7));
    endcase
    t_we[port] = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 271));
    if ($urandom_range(0, 3) != 0 && t_f3[port] == 3'b010) a[1:0] = 2'b00;
    t_addr[port] = a;
    t_wd[port]   = $urandom;
    t_pend[port] = 1'b1;
    drive(port, 1'b1, t_we[port], t_f3[port], t_addr[port], t_wd[port]);
  endtask

  task automatic test_random();
    int n; int cyc; int last_cyc; int w0; int exp_writes;
    bit exp_last; bit exp; bit port; logic [31:0] exp_rd; bit lg;
    apply_reset();
    w0 = wr_count; exp_writes = 0;
    t_pend[0] = 1'b0; t_pend[1] = 1'b0;
    gen(1'b0);
    if ($urandom_range(0, 1) != 0) gen(1'b1);
    n = 0; cyc = 0; last_cyc = 0; exp_last = 1'b1;
    while (n < 60 && cyc < 250) begin
      tick(); cyc++;
      if (p0_ack || p1_ack) begin
        port = p1_ack;
        exp  = (t_pend[0] && t_pend[1]) ? ~exp_last : (t_pend[1] && !t_pend[0]);
        exp_last = exp;
        tests++;
        if (port !== exp || (p0_ack && p1_ack) || grant !== exp) begin
          fails++; $display("FAIL rnd_winner #%0d got p0_ack=%b p1_ack=%b grant=%b want port %0d", n, p0_ack, p1_ack, grant, exp);
        end
        tests++;
        if (cyc - last_cyc !== ((n == 0) ? 2 : 3)) begin
          fails++; $display("FAIL rnd_spacing #%0d got=%0d want=%0d", n, cyc - last_cyc, (n == 0) ? 2 : 3);
        end
        lg = ref_legal(t_we[exp], t_f3[exp], t_addr[exp]);
        tests++;
        if ((port ? p1_err : p0_err) !== ~lg) begin
          fails++; $display("FAIL rnd_err #%0d got=%b want=%b addr=%h f3=%b we=%b", n, port ? p1_err : p0_err, ~lg, t_addr[exp], t_f3[exp], t_we[exp]);
        end
        if (!t_we[exp]) begin
          exp_rd = ref_read(t_f3[exp], t_addr[exp]);
          tests++;
          if ((port ? p1_rdata : p0_rdata) !== exp_rd) begin
            fails++; $display("FAIL rnd_rdata #%0d got=%h want=%h addr=%h f3=%b", n, port ? p1_rdata : p0_rdata, exp_rd, t_addr[exp], t_f3[exp]);
          end
        end else if (lg) begin
          ref_write(t_f3[exp], t_addr[exp], t_wd[exp]);
          exp_writes++;
        end
        t_pend[exp] = 1'b0;
        if ($urandom_range(0, 3) != 0) gen(exp);
        else drive(exp, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        if (!t_pend[~exp] && $urandom_range(0, 1) != 0) gen(~exp);
        if (!t_pend[0] && !t_pend[1]) gen(exp);
        last_cyc = cyc; n++;
      end
    end
    tests++;
    if (n !== 60) begin
      fails++; $display("FAIL rnd_timeout got=%0d acks want=60", n);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tests++;
    if (wr_count - w0 !== exp_writes) begin
      fails++; $display("FAIL rnd_writes got=%0d want=%0d", wr_count - w0, exp_writes);
    end
  endtask

  initial begin
    reset = 1'b1;
    f_p0_req = 1'b0; f_p1_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    poke_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      poke_idx  = 6'(i);
      poke_data = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = poke_data[8*k +: 8];
      tick();
    end
    poke_en = 1'b0;
    test_reset();
    test_write_read();
    test_byte_read();
    test_illegal();
    test_rr_contention();
    test_fixed_prio();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the CPU load/store unit (port 0) and a loader/DMA engine (port 1).
- Uses a req/ack handshake and round-robin or fixed-priority selection.
- Sequences each access through a 3-state FSM, registers read data, and flags illegal funct3 or out-of-range addresses.
- Sits between the core/loader and data_mem; drives data_mem's wr_en, funct3, address and write-data inputs.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- MEM_SIZE, 64, memory depth in words; legal byte addresses are 0 .. MEM_SIZE*4-1
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request; held with stable fields until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_funct3  in  3  port 0 access size: 000 byte, 010 word, 100 byte-unsigned (read only)
- p0_addr  in  ADDR_WIDTH  port 0 byte address
- p0_wdata  in  DATA_WIDTH  port 0 write data
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_err  out  1  port 0 error flag, valid with p0_ack
- p0_rdata  out  DATA_WIDTH  port 0 read data, valid with p0_ack
- p1_req, p1_we, p1_funct3, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  same as port 0
- mem_wr_en  out  1  to data_mem wr_en
- mem_funct3  out  3  to data_mem funct3
- mem_addr  out  ADDR_WIDTH  to data_mem address
- mem_wr_data  out  DATA_WIDTH  to data_mem write data
- mem_rd_data  in  DATA_WIDTH  combinational read data from data_mem
- grant  out  1  port currently owning memory; 0 outside ACCESS/ACK

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). All state is updated on the rising edge of clk.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req is high: select a winner, latch the winner index into gnt_q, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - FIXED_PRIO=1: port 0 wins.
  - FIXED_PRIO=0: on a tie, the port that is not last_q wins. A single requester always wins.
  - last_q is updated to the winner on the IDLE->ACCESS transition.
- ACCESS (exactly one cycle):
  - mem_funct3, mem_addr and mem_wr_data are muxed from the granted port.
  - mem_wr_en = granted we AND legal AND NOT reset, so the write commits at the closing edge.
  - For a read, mem_rd_data is captured into rdata_q and err_q is captured.
  - Next state: ACK.
- ACK:
  - Granted port's ack=1 for exactly one cycle, with rdata = rdata_q and err = err_q.
  - req is ignored in this state. Next state: IDLE.
- Requester rule: a requester samples ack at the edge closing ACK and may change or drop req at that edge.
- Latency and throughput:
  - req seen in IDLE at cycle N, memory access at N+1, ack at N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Legality:
  - Write funct3 must be 000 or 010.
  - Read funct3 must be 000, 010 or 100.
  - Address must be < MEM_SIZE*4; word accesses must have addr[1:0]=00.
  - An illegal access gives mem_wr_en=0, err=1, rdata=0; ack still pulses.
- Non-granted port: ack, err and rdata are 0.
- Outside ACCESS: mem_wr_en=0; mem_addr, mem_wr_data and mem_funct3 are 0.
- Reset values: state=IDLE, last_q=1 (port 0 wins the first tie), gnt_q=0, rdata_q=0, err_q=0, all outputs 0.
- Reset asserted mid-ACCESS: mem_wr_en is forced 0 in that cycle (no write) and the FSM returns to IDLE. The aborted transaction is never acked.
- A req dropped before ack is a protocol violation; the arbiter still completes the latched access.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B=3'b000, F3_W=3'b010, F3_BU=3'b100
  - FSM state encoding (IDLE, ACCESS, ACK)
- One natural sub-module, dmem_rr_pick: 2-way round-robin/fixed-priority selector taking req[1:0], last and FIXED_PRIO, and producing the winner index.
- Legality check and datapath muxes stay in the top module.

Test Plan:
- Single write then read: p0 writes word 0xDEADBEEF to addr 0x10 (funct3 010), then reads the same address -> p0_ack at N+2 both times, p0_rdata=0xDEADBEEF, p0_err=0, mem_wr_en high for exactly one cycle.
- Contention, round-robin: p0 and p1 hold reads continuously after reset -> grant sequence 0,1,0,1; each ack 3 cycles apart; the non-granted ack stays 0.
- FIXED_PRIO=1: both ports hold req -> p0 granted every time; p1 served only once p0 deasserts.
- Illegal access: p1 writes funct3 100 to addr 0x4, then reads addr 0x100 (>= 256) -> p1_ack with p1_err=1, mem_wr_en never asserted, p1_rdata=0.
- Byte read: memory word 0x80 holds 0x12345680; p0 reads addr 0x80 with lb then lbu -> rdata 0xFFFFFF80 then 0x00000080.
- Reset mid-ACCESS: assert reset during a p0 write -> no mem_wr_en pulse, no ack; after reset the state is IDLE and the memory word is unchanged.
